// File: rtl/xtea_sched_if.sv
// Bundle of the two requester ports, the shared cipher-core port and the busy flag.
// master: the environment (requesters and the core); slave: the scheduler.
interface xtea_sched_if;
    logic         req0;
    logic         mode0;
    logic [127:0] v0;
    logic [127:0] k0;
    logic         ack0;
    logic         done0;
    logic         err0;
    logic [127:0] result0;

    logic         req1;
    logic         mode1;
    logic [127:0] v1;
    logic [127:0] k1;
    logic         ack1;
    logic         done1;
    logic         err1;
    logic [127:0] result1;

    logic         core_start;
    logic         core_configuration;
    logic         core_aux;
    logic [127:0] core_v;
    logic [127:0] core_k;
    logic         core_ready;
    logic [127:0] core_data;

    logic         busy;

    modport master (
        output req0, mode0, v0, k0,
        output req1, mode1, v1, k1,
        output core_ready, core_data,
        input  ack0, done0, err0, result0,
        input  ack1, done1, err1, result1,
        input  core_start, core_configuration, core_aux, core_v, core_k,
        input  busy
    );

    modport slave (
        input  req0, mode0, v0, k0,
        input  req1, mode1, v1, k1,
        input  core_ready, core_data,
        output ack0, done0, err0, result0,
        output ack1, done1, err1, result1,
        output core_start, core_configuration, core_aux, core_v, core_k,
        output busy
    );
endinterface

// File: rtl/xtea_sched.sv
// Two-requester round-robin scheduler in front of a single XTEA core.
//
// state | meaning
// IDLE  | arbitrate; on grant capture owner/mode/block/key and pulse ack
// GRANT | configuration presented to the core, aux held low
// START | core_start issued (visible the following cycle)
// ARM   | core_aux raised, timeout counter loaded
// BUSY  | waiting for core_ready; ready beats timeout on the same cycle
// RESP  | done pulse to owner, result registered, round-robin advances
// ERR   | err pulse to owner, result untouched, round-robin advances
//
// Cycle view with the ack cycle as N: core_start is high in N+2, core_aux
// is high for every BUSY cycle, done/err are high during RESP/ERR.
module xtea_sched #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic         clock,
    input  logic         reset,
    xtea_sched_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        ARM,
        BUSY,
        RESP,
        ERR
    } state_t;

    state_t       state;
    logic         owner;
    logic         rr;
    logic         mode_r;
    logic [CNT_W-1:0] tmo_cnt;
    logic [127:0] v_r;
    logic [127:0] k_r;
    logic [127:0] result0_r;
    logic [127:0] result1_r;
    logic         ack0_r;
    logic         ack1_r;
    logic         done0_r;
    logic         done1_r;
    logic         err0_r;
    logic         err1_r;
    logic         start_r;
    logic         aux_r;

    logic         pick1;
    logic         any_req;

    // Requester 1 wins when it is alone or when both ask and it holds the pointer.
    assign pick1   = bus.req1 && (!bus.req0 || rr);
    assign any_req = bus.req0 || bus.req1;

    // Sequencer: arbitration, core control, timeout and result return.
    // The watchdog runs down from TIMEOUT-1; reaching zero in BUSY means
    // TIMEOUT BUSY cycles have elapsed without core_ready.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            rr        <= 1'b0;
            mode_r    <= 1'b0;
            tmo_cnt   <= '0;
            v_r       <= '0;
            k_r       <= '0;
            result0_r <= '0;
            result1_r <= '0;
            ack0_r    <= 1'b0;
            ack1_r    <= 1'b0;
            done0_r   <= 1'b0;
            done1_r   <= 1'b0;
            err0_r    <= 1'b0;
            err1_r    <= 1'b0;
            start_r   <= 1'b0;
            aux_r     <= 1'b0;
        end else begin
            ack0_r  <= 1'b0;
            ack1_r  <= 1'b0;
            done0_r <= 1'b0;
            done1_r <= 1'b0;
            err0_r  <= 1'b0;
            err1_r  <= 1'b0;
            start_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner  <= pick1;
                        mode_r <= pick1 ? bus.mode1 : bus.mode0;
                        v_r    <= pick1 ? bus.v1 : bus.v0;
                        k_r    <= pick1 ? bus.k1 : bus.k0;
                        ack0_r <= !pick1;
                        ack1_r <= pick1;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    aux_r <= 1'b0;
                    state <= START;
                end
                START: begin
                    start_r <= 1'b1;
                    state   <= ARM;
                end
                ARM: begin
                    aux_r   <= 1'b1;
                    tmo_cnt <= CNT_W'(TIMEOUT - 1);
                    state   <= BUSY;
                end
                BUSY: begin
                    if (bus.core_ready) begin
                        if (owner) begin
                            result1_r <= bus.core_data;
                            done1_r   <= 1'b1;
                        end else begin
                            result0_r <= bus.core_data;
                            done0_r   <= 1'b1;
                        end
                        aux_r <= 1'b0;
                        state <= RESP;
                    end else if (tmo_cnt == '0) begin
                        err0_r <= !owner;
                        err1_r <= owner;
                        aux_r  <= 1'b0;
                        state  <= ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                RESP: begin
                    rr    <= !owner;
                    state <= IDLE;
                end
                ERR: begin
                    rr    <= !owner;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack0               = ack0_r;
    assign bus.ack1               = ack1_r;
    assign bus.done0              = done0_r;
    assign bus.done1              = done1_r;
    assign bus.err0               = err0_r;
    assign bus.err1               = err1_r;
    assign bus.result0            = result0_r;
    assign bus.result1            = result1_r;
    assign bus.core_start         = start_r;
    assign bus.core_configuration = mode_r;
    assign bus.core_aux           = aux_r;
    assign bus.core_v             = v_r;
    assign bus.core_k             = k_r;
    assign bus.busy               = (state != IDLE);

endmodule

// File: tb/tb_xtea_sched.sv
// Directed bench for xtea_sched: one instance with the default timeout for
// the functional scenarios, one with TIMEOUT=8 for watchdog behaviour.
module tb_xtea_sched;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [127:0] V_A = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [127:0] K_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] D_A = 128'ha5a5a5a5a5a5a5a5_a5a5a5a5a5a5a5a5;
    localparam logic [127:0] V_B = 128'hdeadbeefcafef00d_0badc0de12345678;
    localparam logic [127:0] K_B = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] D_B = 128'h5a5a5a5a5a5a5a5a_5a5a5a5a5a5a5a5a;
    localparam logic [127:0] D_J = 128'h0000000000000000_00000000deadd00d;
    localparam logic [127:0] D_T = 128'h1357924680aceace_2468135799bdbdbd;
    localparam logic [127:0] D_M = 128'h0f0f0f0f0f0f0f0f_f0f0f0f0f0f0f0f0;

    // Clock generation.
    always #5 clock = ~clock;

    xtea_sched_if ia ();
    xtea_sched_if ib ();

    xtea_sched #(.TIMEOUT(255), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ia)
    );

    xtea_sched #(.TIMEOUT(8), .CNT_W(16)) dut_t (
        .clock (clock),
        .reset (reset),
        .bus   (ib)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        ia.req0 = 0; ia.mode0 = 0; ia.v0 = '0; ia.k0 = '0;
        ia.req1 = 0; ia.mode1 = 0; ia.v1 = '0; ia.k1 = '0;
        ia.core_ready = 0; ia.core_data = '0;
        ib.req0 = 0; ib.mode0 = 0; ib.v0 = '0; ib.k0 = '0;
        ib.req1 = 0; ib.mode1 = 0; ib.v1 = '0; ib.k1 = '0;
        ib.core_ready = 0; ib.core_data = '0;
    endtask

    task automatic test_reset();
        logic [11:0] flags_a;
        logic [11:0] flags_b;
        reset = 0;
        tick();
        tick();
        flags_a = {ia.ack0, ia.ack1, ia.done0, ia.done1, ia.err0, ia.err1,
                   ia.core_start, ia.core_aux, ia.core_configuration, ia.busy, 2'b00};
        flags_b = {ib.ack0, ib.ack1, ib.done0, ib.done1, ib.err0, ib.err1,
                   ib.core_start, ib.core_aux, ib.core_configuration, ib.busy, 2'b00};
        n_checks++;
        if (flags_a !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_flags_a: got %b expected 000000000000", flags_a);
        end
        n_checks++;
        if (flags_b !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_flags_b: got %b expected 000000000000", flags_b);
        end
        n_checks++;
        if ((ia.result0 | ia.result1 | ia.core_v | ia.core_k) !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: got r0=%h r1=%h v=%h k=%h expected all zero",
                     ia.result0, ia.result1, ia.core_v, ia.core_k);
        end
    endtask

    task automatic test_single_job();
        bit early;
        reset = 1;
        ia.req0 = 1; ia.mode0 = 0; ia.v0 = V_A; ia.k0 = K_A;
        tick();                                   // N: GRANT
        n_checks++;
        if (ia.ack0 !== 1'b1 || ia.ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack: got ack0=%b ack1=%b expected 1 0", ia.ack0, ia.ack1);
        end
        n_checks++;
        if (ia.core_v !== V_A || ia.core_k !== K_A) begin
            n_fail++;
            $display("FAIL single_operands: got v=%h k=%h expected v=%h k=%h",
                     ia.core_v, ia.core_k, V_A, K_A);
        end
        ia.req0 = 0; ia.v0 = '0; ia.k0 = '0;
        tick();                                   // N+1: START
        n_checks++;
        if (ia.core_start !== 1'b0 || ia.ack0 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_n1: got start=%b ack0=%b expected 0 0", ia.core_start, ia.ack0);
        end
        tick();                                   // N+2: ARM
        n_checks++;
        if (ia.core_start !== 1'b1) begin
            n_fail++;
            $display("FAIL single_start: got core_start=%b expected 1 at N+2", ia.core_start);
        end
        tick();                                   // N+3: first BUSY
        n_checks++;
        if (ia.core_aux !== 1'b1 || ia.core_configuration !== 1'b0 ||
            ia.core_start !== 1'b0 || ia.core_v !== V_A) begin
            n_fail++;
            $display("FAIL single_busy: got aux=%b cfg=%b start=%b v=%h expected 1 0 0 %h",
                     ia.core_aux, ia.core_configuration, ia.core_start, ia.core_v, V_A);
        end
        early = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ia.done0 !== 1'b0 || ia.core_aux !== 1'b1) early = 1;
        end
        ia.core_ready = 1; ia.core_data = D_A;    // 40 cycles after aux rose
        tick();                                   // RESP
        ia.core_ready = 0; ia.core_data = '0;
        n_checks++;
        if (early) begin
            n_fail++;
            $display("FAIL single_wait: got early done0 or aux drop expected none");
        end
        n_checks++;
        if (ia.done0 !== 1'b1 || ia.done1 !== 1'b0 || ia.core_aux !== 1'b0 || ia.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_done: got done0=%b done1=%b aux=%b busy=%b expected 1 0 0 1",
                     ia.done0, ia.done1, ia.core_aux, ia.busy);
        end
        n_checks++;
        if (ia.result0 !== D_A || ia.result1 !== 128'h0) begin
            n_fail++;
            $display("FAIL single_result: got r0=%h r1=%h expected r0=%h r1=0",
                     ia.result0, ia.result1, D_A);
        end
        tick();
        n_checks++;
        if (ia.done0 !== 1'b0 || ia.busy !== 1'b0 || ia.result0 !== D_A) begin
            n_fail++;
            $display("FAIL single_idle: got done0=%b busy=%b r0=%h expected 0 0 %h",
                     ia.done0, ia.busy, ia.result0, D_A);
        end
    endtask

    task automatic test_encrypt();
        bit cfg_bad;
        cfg_bad = 0;
        ia.req1 = 1; ia.mode1 = 1; ia.v1 = V_B; ia.k1 = K_B;
        tick();                                   // GRANT
        n_checks++;
        if (ia.ack1 !== 1'b1 || ia.ack0 !== 1'b0) begin
            n_fail++;
            $display("FAIL enc_ack: got ack0=%b ack1=%b expected 0 1", ia.ack0, ia.ack1);
        end
        if (ia.core_configuration !== 1'b1) cfg_bad = 1;
        ia.req1 = 0;
        tick();                                   // START: stray ready must be ignored
        if (ia.core_configuration !== 1'b1) cfg_bad = 1;
        ia.core_ready = 1; ia.core_data = D_J;
        tick();                                   // ARM
        ia.core_ready = 0; ia.core_data = '0;
        if (ia.core_configuration !== 1'b1) cfg_bad = 1;
        tick();                                   // BUSY
        if (ia.core_configuration !== 1'b1 || ia.core_aux !== 1'b1) cfg_bad = 1;
        n_checks++;
        if (cfg_bad || ia.done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL enc_config: got cfg_bad=%b done1=%b expected 0 0", cfg_bad, ia.done1);
        end
        ia.core_ready = 1; ia.core_data = D_B;
        tick();                                   // RESP
        ia.core_ready = 0; ia.core_data = '0;
        n_checks++;
        if (ia.done1 !== 1'b1 || ia.done0 !== 1'b0 || ia.result1 !== D_B || ia.result0 !== D_A) begin
            n_fail++;
            $display("FAIL enc_done: got done1=%b done0=%b r1=%h r0=%h expected 1 0 %h %h",
                     ia.done1, ia.done0, ia.result1, ia.result0, D_B, D_A);
        end
        n_checks++;
        if (ia.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL enc_busy_resp: got busy=%b expected 1", ia.busy);
        end
        tick();
        n_checks++;
        if (ia.busy !== 1'b0 || ia.done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL enc_busy_fall: got busy=%b done1=%b expected 0 0", ia.busy, ia.done1);
        end
    endtask

    task automatic test_contention();
        logic [127:0] dc [4];
        logic [127:0] res_m0;
        logic [127:0] res_m1;
        bit got;
        bit seen;
        bit both;
        bit exp_owner;
        dc[0] = 128'h1111111111111111_1111111111111111;
        dc[1] = 128'h2222222222222222_2222222222222222;
        dc[2] = 128'h3333333333333333_3333333333333333;
        dc[3] = 128'h4444444444444444_4444444444444444;
        res_m0 = '0;
        res_m1 = '0;
        reset = 0;
        tick();
        reset = 1;
        ia.req0 = 1; ia.mode0 = 0; ia.v0 = V_A; ia.k0 = K_A;
        ia.req1 = 1; ia.mode1 = 1; ia.v1 = V_B; ia.k1 = K_B;
        for (int j = 0; j < 4; j++) begin
            exp_owner = j[0];
            got = 0; seen = 0; both = 0;
            for (int c = 0; c < 20 && !got; c++) begin
                tick();
                if (ia.ack0 === 1'b1 && ia.ack1 === 1'b1) both = 1;
                if (ia.ack0 === 1'b1 || ia.ack1 === 1'b1) begin
                    got  = 1;
                    seen = ia.ack1;
                end
            end
            n_checks++;
            if (!got || seen !== exp_owner) begin
                n_fail++;
                $display("FAIL contention_grant job %0d: got ack=%b owner=%b expected owner %b",
                         j, got, seen, exp_owner);
            end
            n_checks++;
            if (both) begin
                n_fail++;
                $display("FAIL contention_overlap job %0d: got both acks high expected one", j);
            end
            for (int c = 0; c < 10 && ia.core_aux !== 1'b1; c++) tick();
            ia.core_ready = 1; ia.core_data = dc[j];
            tick();
            ia.core_ready = 0; ia.core_data = '0;
            if (exp_owner) res_m1 = dc[j];
            else           res_m0 = dc[j];
            n_checks++;
            if (ia.result0 !== res_m0 || ia.result1 !== res_m1 ||
                (exp_owner ? ia.done1 : ia.done0) !== 1'b1) begin
                n_fail++;
                $display("FAIL contention_result job %0d: got r0=%h r1=%h d0=%b d1=%b expected r0=%h r1=%h",
                         j, ia.result0, ia.result1, ia.done0, ia.done1, res_m0, res_m1);
            end
        end
        ia.req0 = 0; ia.req1 = 0;
        tick();
        tick();
    endtask

    task automatic test_tie();
        ib.req0 = 1; ib.mode0 = 1; ib.v0 = V_A; ib.k0 = K_A;
        tick();                                   // GRANT
        ib.req0 = 0;
        tick();                                   // START
        tick();                                   // ARM
        tick();                                   // BUSY 1
        for (int i = 0; i < 7; i++) tick();       // BUSY 8: last timeout cycle
        ib.core_ready = 1; ib.core_data = D_T;
        tick();
        ib.core_ready = 0; ib.core_data = '0;
        n_checks++;
        if (ib.done0 !== 1'b1 || ib.err0 !== 1'b0 || ib.result0 !== D_T) begin
            n_fail++;
            $display("FAIL tie_done: got done0=%b err0=%b r0=%h expected 1 0 %h",
                     ib.done0, ib.err0, ib.result0, D_T);
        end
        tick();
        n_checks++;
        if (ib.err0 !== 1'b0 || ib.done0 !== 1'b0 || ib.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_after: got err0=%b done0=%b busy=%b expected 0 0 0",
                     ib.err0, ib.done0, ib.busy);
        end
    endtask

    task automatic test_timeout();
        bit early;
        bit saw_err1;
        ib.req0 = 1; ib.v0 = V_B; ib.k0 = K_B;
        tick();                                   // GRANT
        ib.req0 = 0;
        tick();                                   // START
        tick();                                   // ARM
        n_checks++;
        if (ib.core_start !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_start: got core_start=%b expected 1", ib.core_start);
        end
        early = 0;
        for (int i = 0; i < 8; i++) begin         // eight BUSY cycles
            tick();
            if (ib.err0 !== 1'b0 || ib.done0 !== 1'b0 || ib.core_aux !== 1'b1) early = 1;
        end
        n_checks++;
        if (early) begin
            n_fail++;
            $display("FAIL tmo_early: got err/done or aux drop within 8 BUSY cycles expected none");
        end
        tick();                                   // ERR
        n_checks++;
        if (ib.err0 !== 1'b1 || ib.done0 !== 1'b0 || ib.core_aux !== 1'b0 || ib.result0 !== D_T) begin
            n_fail++;
            $display("FAIL tmo_err: got err0=%b done0=%b aux=%b r0=%h expected 1 0 0 %h",
                     ib.err0, ib.done0, ib.core_aux, ib.result0, D_T);
        end
        tick();
        n_checks++;
        if (ib.err0 !== 1'b0 || ib.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_after: got err0=%b busy=%b expected 0 0", ib.err0, ib.busy);
        end
        ib.req0 = 1; ib.req1 = 1;
        tick();
        n_checks++;
        if (ib.ack1 !== 1'b1 || ib.ack0 !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_next_grant: got ack0=%b ack1=%b expected 0 1", ib.ack0, ib.ack1);
        end
        ib.req0 = 0; ib.req1 = 0;
        saw_err1 = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ib.err1 === 1'b1) saw_err1 = 1;
        end
        n_checks++;
        if (!saw_err1 || ib.busy !== 1'b0 || ib.result1 !== 128'h0) begin
            n_fail++;
            $display("FAIL tmo_req1: got err1_seen=%b busy=%b r1=%h expected 1 0 0",
                     saw_err1, ib.busy, ib.result1);
        end
    endtask

    task automatic test_reset_mid_busy();
        bit stray;
        ia.req0 = 1; ia.v0 = V_A; ia.k0 = K_A;
        tick();                                   // GRANT
        ia.req0 = 0;
        tick(); tick(); tick();                   // START, ARM, BUSY
        ia.core_ready = 1; ia.core_data = D_M;
        tick();                                   // RESP, pointer moves to 1
        ia.core_ready = 0; ia.core_data = '0;
        tick();                                   // IDLE
        ia.req1 = 1; ia.v1 = V_B; ia.k1 = K_B;
        tick();                                   // GRANT
        ia.req1 = 0;
        tick(); tick(); tick(); tick();           // START, ARM, BUSY, BUSY
        n_checks++;
        if (ia.core_aux !== 1'b1 || ia.result0 !== D_M) begin
            n_fail++;
            $display("FAIL midrst_pre: got aux=%b r0=%h expected 1 %h", ia.core_aux, ia.result0, D_M);
        end
        reset = 0;
        tick();
        reset = 1;
        n_checks++;
        if (ia.core_aux !== 1'b0 || ia.busy !== 1'b0 || ia.done1 !== 1'b0 || ia.err1 !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state: got aux=%b busy=%b done1=%b err1=%b expected 0 0 0 0",
                     ia.core_aux, ia.busy, ia.done1, ia.err1);
        end
        stray = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (ia.done0 | ia.done1 | ia.err0 | ia.err1 | ia.busy) stray = 1;
        end
        n_checks++;
        if (stray || ia.result1 !== 128'h0) begin
            n_fail++;
            $display("FAIL midrst_quiet: got stray=%b r1=%h expected 0 0", stray, ia.result1);
        end
        ia.req0 = 1; ia.req1 = 1;
        tick();
        n_checks++;
        if (ia.ack0 !== 1'b1 || ia.ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_pointer: got ack0=%b ack1=%b expected 1 0", ia.ack0, ia.ack1);
        end
        ia.req0 = 0; ia.req1 = 0;
        for (int c = 0; c < 10 && ia.core_aux !== 1'b1; c++) tick();
        ia.core_ready = 1; ia.core_data = D_A;
        tick();
        ia.core_ready = 0; ia.core_data = '0;
        tick();
    endtask

    // Global time limit so a stuck run still ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "time limit");
    end

    // Scenario sequence.
    initial begin
        clear_inputs();
        test_reset();
        test_single_job();
        test_encrypt();
        test_contention();
        test_tie();
        test_timeout();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
